// File: rtl/secuenciador_control.sv
// secuenciador_control: fetch/decode sequencer for the 4-bit ALU datapath (optional SINGLE_STEP_EN adds step input and WAIT state)
module secuenciador_control #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [7:0]        instr_in,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [2:0]        alu_op,
  output logic [3:0]        data_out,
  output logic              en_bus1,
  output logic              en_accu,
  output logic              en_bus2,
  output logic              halted
);
  typedef enum logic [2:0] {
    FETCH, EXEC, OPERAND, HALT
`ifdef SINGLE_STEP_EN
    , WAIT
`endif
  } state_t;
`ifdef SINGLE_STEP_EN
  localparam state_t DONE = WAIT;
`else
  localparam state_t DONE = FETCH;
`endif
  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        ir;
  logic              c_flag, z_flag;
  logic [3:0]        op;
  logic [2:0]        d_alu;
  logic              is_jmp, is_halt, d_bus1, d_accu, take;
  assign op     = instr_in[7:4];
  assign pc_out = pc;
  // decode the byte being fetched and the jump condition of the latched opcode
  always_comb begin
    is_jmp  = op >= 4'h8 && op <= 4'hC;
    is_halt = op == 4'hF;
    d_bus1  = op >= 4'h1 && op <= 4'h4;
    d_accu  = d_bus1 && op != 4'h3;
    d_alu   = op == 4'h1 ? 3'b010 : op == 4'h2 ? 3'b011 : op == 4'h3 ? 3'b001 : op == 4'h4 ? 3'b100 : 3'b000;
    take    = ir == 4'h8 ? 1'b1 : ir == 4'h9 ? c_flag : ir == 4'hA ? !c_flag :
              ir == 4'hB ? z_flag : ir == 4'hC ? !z_flag : 1'b0;
  end
  // sequencer FSM; datapath controls are registered at FETCH so they are live exactly during EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= '0;
      ir       <= '0;
      c_flag   <= 1'b0;
      z_flag   <= 1'b0;
      alu_op   <= '0;
      data_out <= '0;
      en_bus1  <= 1'b0;
      en_accu  <= 1'b0;
      en_bus2  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      alu_op   <= '0;
      data_out <= '0;
      en_bus1  <= 1'b0;
      en_accu  <= 1'b0;
      en_bus2  <= 1'b0;
      case (state)
        FETCH: begin
          ir     <= op;
          pc     <= pc + 1'b1;
          state  <= is_jmp ? OPERAND : is_halt ? HALT : EXEC;
          halted <= is_halt;
          alu_op   <= d_alu;
          data_out <= d_bus1 ? instr_in[3:0] : 4'h0;
          en_bus1  <= d_bus1;
          en_accu  <= d_accu;
          en_bus2  <= op == 4'h5;
        end
        EXEC: begin
          if (en_bus1) begin
            c_flag <= carry_in;
            z_flag <= zero_in;
          end
          state <= DONE;
        end
        OPERAND: begin
          pc    <= take ? ADDR_W'(instr_in) : pc + 1'b1;
          state <= DONE;
        end
        HALT: state <= HALT;
`ifdef SINGLE_STEP_EN
        WAIT: state <= step ? FETCH : WAIT;
`endif
        default: state <= FETCH;
      endcase
    end
  end
endmodule
